// File: rtl/counter_increment_arbiter_pkg.sv
// Shared types and constants for the involuntary counter increment arbiter.
// Counter words are 15-bit one's complement values held in erasable memory.
package counter_increment_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GRANT,
        READ,
        MODIFY,
        WRITE
    } stateT;

    localparam logic [14:0] POS_MAX  = 15'o37777;
    localparam logic [14:0] NEG_MAX  = 15'o40000;
    localparam logic [14:0] NEG_ZERO = 15'o77777;

    localparam logic [10:0] CNT_BASE_ADDR_DEF = 11'o24;

    localparam logic DIR_INC = 1'b0;
    localparam logic DIR_DEC = 1'b1;

endpackage

// File: rtl/counter_increment_arbiter_ones_comp_step.sv
// Combinational +1/-1 step on a 15-bit one's complement word.
// Both zeros step away from zero; crossing the positive/negative limit flags overflow.
module ones_comp_step
    import counter_increment_arbiter_pkg::*;
(
    input  logic [14:0] value,
    input  logic        dir,
    output logic [14:0] result,
    output logic        ovf
);

    always_comb begin
        result = value;
        ovf    = 1'b0;
        if (dir == DIR_INC) begin
            if (value == POS_MAX) begin
                result = 15'o00000;
                ovf    = 1'b1;
            end else if (value == NEG_ZERO) begin
                result = 15'o00001;
            end else begin
                result = value + 15'd1;
            end
        end else begin
            if (value == NEG_MAX) begin
                result = NEG_ZERO;
                ovf    = 1'b1;
            end else if (value == 15'o00000) begin
                result = 15'o77776;
            end else begin
                result = value - 15'd1;
            end
        end
    end

endmodule

// File: rtl/counter_increment_arbiter.sv
// Collects +1/-1 requests for a bank of memory-resident counters and applies them
// by stalling the core and doing read-modify-write cycles on the shared RAM.
module counter_increment_arbiter
    import counter_increment_arbiter_pkg::*;
#(
    parameter int          NUM_CNT       = 8,
    parameter logic [10:0] CNT_BASE_ADDR = CNT_BASE_ADDR_DEF,
    parameter int          MAX_BURST     = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_CNT-1:0] inc_req,
    input  logic [NUM_CNT-1:0] dec_req,
    output logic               core_stall_req,
    input  logic               core_grant,
    output logic               ram_own,
    output logic [10:0]        ram_read_address,
    input  logic [14:0]        ram_read_data,
    output logic [10:0]        ram_write_address,
    output logic [14:0]        ram_write_data,
    output logic               ram_write_en,
    output logic [NUM_CNT-1:0] overflow
);

    localparam int SEL_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    stateT              r_state;
    stateT              w_nextState;
    logic [NUM_CNT-1:0] r_pendInc;
    logic [NUM_CNT-1:0] r_pendDec;
    logic [SEL_W-1:0]   r_sel;
    logic               r_dir;
    logic [BURST_W-1:0] r_burst;
    logic [14:0]        r_result;
    logic               r_ovf;

    logic [SEL_W-1:0]   w_pickIdx;
    logic               w_pickDir;
    logic               w_anyPend;
    logic               w_enterRead;
    logic [NUM_CNT-1:0] w_clrInc;
    logic [NUM_CNT-1:0] w_clrDec;
    logic [10:0]        w_cntAddr;
    logic [14:0]        w_stepResult;
    logic               w_stepOvf;

    // Lowest index wins; the downward scan lets the last hit be the lowest.
    always_comb begin
        w_pickIdx = '0;
        w_pickDir = DIR_INC;
        for (int i = NUM_CNT - 1; i >= 0; i--) begin
            if (r_pendInc[i] || r_pendDec[i]) begin
                w_pickIdx = SEL_W'(i);
                w_pickDir = r_pendInc[i] ? DIR_INC : DIR_DEC;
            end
        end
    end

    assign w_anyPend = |(r_pendInc | r_pendDec);
    assign w_cntAddr = CNT_BASE_ADDR + 11'(r_sel);
    assign w_clrInc  = (w_enterRead && (w_pickDir == DIR_INC)) ? (NUM_CNT'(1) << w_pickIdx) : '0;
    assign w_clrDec  = (w_enterRead && (w_pickDir == DIR_DEC)) ? (NUM_CNT'(1) << w_pickIdx) : '0;

    ones_comp_step u_step (
        .value  (ram_read_data),
        .dir    (r_dir),
        .result (w_stepResult),
        .ovf    (w_stepOvf)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState       = r_state;
        w_enterRead       = 1'b0;
        core_stall_req    = 1'b0;
        ram_own           = 1'b0;
        ram_read_address  = '0;
        ram_write_address = '0;
        ram_write_data    = '0;
        ram_write_en      = 1'b0;
        overflow          = '0;
        case (r_state)
            IDLE: begin
                if (w_anyPend) begin
                    w_nextState = WAIT_GRANT;
                end
            end
            WAIT_GRANT: begin
                core_stall_req = 1'b1;
                if (core_grant) begin
                    w_nextState = READ;
                    w_enterRead = 1'b1;
                end
            end
            READ: begin
                core_stall_req   = 1'b1;
                ram_own          = 1'b1;
                ram_read_address = w_cntAddr;
                w_nextState      = MODIFY;
            end
            MODIFY: begin
                core_stall_req = 1'b1;
                ram_own        = 1'b1;
                w_nextState    = WRITE;
            end
            WRITE: begin
                core_stall_req    = 1'b1;
                ram_own           = 1'b1;
                ram_write_en      = 1'b1;
                ram_write_address = w_cntAddr;
                ram_write_data    = r_result;
                overflow          = r_ovf ? (NUM_CNT'(1) << r_sel) : '0;
                // Leaving through IDLE gives the core at least one unstalled cycle.
                if (w_anyPend && (r_burst < BURST_W'(MAX_BURST))) begin
                    w_nextState = READ;
                    w_enterRead = 1'b1;
                end else begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // A new pulse beats the clear of the same bit, so it is never lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pendInc <= '0;
            r_pendDec <= '0;
            r_sel     <= '0;
            r_dir     <= DIR_INC;
            r_burst   <= '0;
            r_result  <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_pendInc <= (r_pendInc & ~w_clrInc) | inc_req;
            r_pendDec <= (r_pendDec & ~w_clrDec) | dec_req;
            if (w_enterRead) begin
                r_sel   <= w_pickIdx;
                r_dir   <= w_pickDir;
                r_burst <= r_burst + BURST_W'(1);
            end else if (r_state == IDLE) begin
                r_burst <= '0;
            end
            if (r_state == MODIFY) begin
                r_result <= w_stepResult;
                r_ovf    <= w_stepOvf;
            end
        end
    end

endmodule

// File: tb/tb_counter_increment_arbiter.sv
// Bench for counter_increment_arbiter: directed vector table, multi-cycle corner
// sequences, and a randomized run scored against a request-level reference model.
module tb_counter_increment_arbiter;

    localparam int NUM_CNT   = 8;
    localparam int MAX_BURST = 4;
    localparam int BASE      = 'o24;

    logic               clock = 1'b0;
    logic               reset;
    logic [NUM_CNT-1:0] inc_req;
    logic [NUM_CNT-1:0] dec_req;
    logic               core_stall_req;
    logic               core_grant;
    logic               ram_own;
    logic [10:0]        ram_read_address;
    logic [14:0]        ram_read_data;
    logic [10:0]        ram_write_address;
    logic [14:0]        ram_write_data;
    logic               ram_write_en;
    logic [NUM_CNT-1:0] overflow;

    counter_increment_arbiter #(
        .NUM_CNT       (NUM_CNT),
        .CNT_BASE_ADDR (11'o24),
        .MAX_BURST     (MAX_BURST)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .inc_req           (inc_req),
        .dec_req           (dec_req),
        .core_stall_req    (core_stall_req),
        .core_grant        (core_grant),
        .ram_own           (ram_own),
        .ram_read_address  (ram_read_address),
        .ram_read_data     (ram_read_data),
        .ram_write_address (ram_write_address),
        .ram_write_data    (ram_write_data),
        .ram_write_en      (ram_write_en),
        .overflow          (overflow)
    );

    always #5 clock = ~clock;

    // Erasable memory model with synchronous read and a preload port for the bench.
    logic [14:0] mem [0:2047];
    logic        loadEn = 1'b0;
    logic [10:0] loadAddr = '0;
    logic [14:0] loadData = '0;

    always @(posedge clock) begin
        if (loadEn) begin
            mem[loadAddr] <= loadData;
        end else if (ram_write_en) begin
            mem[ram_write_address] <= ram_write_data;
        end
        ram_read_data <= mem[ram_read_address];
    end

    typedef struct {
        int          idx;
        bit          isDec;
        logic [14:0] init;
        logic [14:0] expVal;
        bit          expOvf;
    } vecT;

    vecT vecs[10];
    int  nChecks = 0;
    int  nFails  = 0;

    logic [10:0] wrAddr [8];
    logic [14:0] wrData [8];
    bit          wrGap  [8];

    // Reference model state for the randomized run.
    int                 mCnt [NUM_CNT];
    logic [NUM_CNT-1:0] mPendInc;
    logic [NUM_CNT-1:0] mPendDec;
    logic [NUM_CNT-1:0] lastInc;
    logic [NUM_CNT-1:0] lastDec;
    int                 sinceRead;
    int                 burstReads;
    int                 expIdx;
    bit                 expDec;
    bit                 checkCont;
    bit                 expectCont;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic int refStep(input int v, input bit isDec, output bit ovf);
        ovf = 1'b0;
        if (!isDec) begin
            if (v == 'o37777) begin
                ovf = 1'b1;
                return 0;
            end
            if (v == 'o77777) return 1;
            return (v + 1) % 32768;
        end
        if (v == 'o40000) begin
            ovf = 1'b1;
            return 'o77777;
        end
        if (v == 0) return 'o77776;
        return v - 1;
    endfunction

    task automatic loadWord(input int addr, input int data);
        loadAddr = 11'(addr);
        loadData = 15'(data);
        loadEn   = 1'b1;
        @(negedge clock);
        loadEn   = 1'b0;
    endtask

    task automatic applyStimulus(input logic [NUM_CNT-1:0] incMask, input logic [NUM_CNT-1:0] decMask);
        inc_req = incMask;
        dec_req = decMask;
        @(negedge clock);
        inc_req = '0;
        dec_req = '0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    // Called on the negedge after a pulse was sampled; that edge counts as cycle 1.
    task automatic waitWrite(input int maxCycles, output int cycles, output bit seen);
        cycles = 1;
        seen   = ram_write_en;
        while (!seen && cycles < maxCycles) begin
            @(negedge clock);
            cycles++;
            seen = ram_write_en;
        end
    endtask

    task automatic collectWrites(input int want, input int maxCycles, output int got);
        bit gap = 1'b0;
        got = 0;
        for (int c = 0; c < maxCycles && got < want; c++) begin
            if (!core_stall_req) gap = 1'b1;
            if (ram_write_en) begin
                wrAddr[got] = ram_write_address;
                wrData[got] = ram_write_data;
                wrGap[got]  = gap;
                gap = 1'b0;
                got++;
            end
            if (got < want) @(negedge clock);
        end
    endtask

    // One negedge of scoring: pending sets are tracked per request, the selection
    // rule and the +/-1 rule are applied from the model, DUT only marks when.
    task automatic monitorStep();
        int  pick;
        int  expV;
        bit  eOvf;
        bit  wroteNow = 1'b0;
        if (checkCont) begin
            checkOutput("burstContinue", 32'(ram_own), 32'(expectCont));
            if (!expectCont) checkOutput("fairGap", 32'(core_stall_req), 32'd0);
            checkCont = 1'b0;
        end
        if (!core_stall_req) burstReads = 0;
        if (sinceRead >= 0) sinceRead++;
        if (sinceRead == 2 || ram_write_en) begin
            checkOutput("writeStrobeTiming", 32'(ram_write_en), 32'(sinceRead == 2));
            if (sinceRead == 2) begin
                expV = refStep(mCnt[expIdx], expDec, eOvf);
                checkOutput($sformatf("rndWrAddr[%0d]", expIdx), 32'(ram_write_address), 32'(BASE + expIdx));
                checkOutput($sformatf("rndWrData[%0d]", expIdx), 32'(ram_write_data), 32'(expV));
                checkOutput($sformatf("rndOvf[%0d]", expIdx), 32'(overflow), eOvf ? (32'd1 << expIdx) : 32'd0);
                mCnt[expIdx] = expV;
                sinceRead = -1;
                wroteNow  = 1'b1;
            end
        end
        if (ram_own && sinceRead < 0 && !wroteNow) begin
            pick = -1;
            for (int i = NUM_CNT - 1; i >= 0; i--) begin
                if (mPendInc[i] || mPendDec[i]) pick = i;
            end
            checkOutput("readHasPending", 32'(pick >= 0), 32'd1);
            if (pick >= 0) begin
                expIdx = pick;
                expDec = !mPendInc[pick];
                if (expDec) mPendDec[pick] = 1'b0;
                else        mPendInc[pick] = 1'b0;
                checkOutput("rndReadAddr", 32'(ram_read_address), 32'(BASE + pick));
            end
            burstReads++;
            checkOutput("burstLimit", 32'(burstReads <= MAX_BURST), 32'd1);
            sinceRead = 0;
        end
        mPendInc = mPendInc | lastInc;
        mPendDec = mPendDec | lastDec;
        if (wroteNow) begin
            expectCont = ((mPendInc | mPendDec) != '0) && (burstReads < MAX_BURST);
            checkCont  = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  cyc;
        bit  seen;
        int  got;
        int  v;
        bit  ovfTmp;
        int  specials[6];
        int  initVals[NUM_CNT];
        bit  sawWrite;
        bit  sawStall;

        vecs[0] = '{2, 1'b0, 15'o00005, 15'o00006, 1'b0};
        vecs[1] = '{0, 1'b0, 15'o37777, 15'o00000, 1'b1};
        vecs[2] = '{1, 1'b1, 15'o00000, 15'o77776, 1'b0};
        vecs[3] = '{1, 1'b1, 15'o40000, 15'o77777, 1'b1};
        vecs[4] = '{4, 1'b0, 15'o77777, 15'o00001, 1'b0};
        vecs[5] = '{5, 1'b1, 15'o00001, 15'o00000, 1'b0};
        vecs[6] = '{6, 1'b0, 15'o77776, 15'o77777, 1'b0};
        vecs[7] = '{7, 1'b1, 15'o77777, 15'o77776, 1'b0};
        vecs[8] = '{3, 1'b0, 15'o40000, 15'o40001, 1'b0};
        vecs[9] = '{0, 1'b1, 15'o37777, 15'o37776, 1'b0};

        reset      = 1'b1;
        inc_req    = '0;
        dec_req    = '0;
        core_grant = 1'b1;
        idleCycles(3);
        checkOutput("rstStall", 32'(core_stall_req), 32'd0);
        checkOutput("rstOwn", 32'(ram_own), 32'd0);
        checkOutput("rstWrEn", 32'(ram_write_en), 32'd0);
        checkOutput("rstOvf", 32'(overflow), 32'd0);
        checkOutput("rstRdAddr", 32'(ram_read_address), 32'd0);
        checkOutput("rstWrAddr", 32'(ram_write_address), 32'd0);
        checkOutput("rstWrData", 32'(ram_write_data), 32'd0);
        reset = 1'b0;
        idleCycles(2);

        $display("[TB] directed vector table");
        for (int k = 0; k < 10; k++) begin
            loadWord(BASE + vecs[k].idx, int'(vecs[k].init));
            if (vecs[k].isDec) applyStimulus('0, NUM_CNT'(1) << vecs[k].idx);
            else               applyStimulus(NUM_CNT'(1) << vecs[k].idx, '0);
            waitWrite(20, cyc, seen);
            checkOutput($sformatf("vec%0d writeSeen", k), 32'(seen), 32'd1);
            checkOutput($sformatf("vec%0d latency", k), 32'(cyc), 32'd5);
            checkOutput($sformatf("vec%0d wrAddr", k), 32'(ram_write_address), 32'(BASE + vecs[k].idx));
            checkOutput($sformatf("vec%0d wrData", k), 32'(ram_write_data), 32'(vecs[k].expVal));
            checkOutput($sformatf("vec%0d overflow", k), 32'(overflow),
                        vecs[k].expOvf ? (32'd1 << vecs[k].idx) : 32'd0);
            @(negedge clock);
            checkOutput($sformatf("vec%0d strobeSingle", k), 32'(ram_write_en), 32'd0);
            checkOutput($sformatf("vec%0d backToIdle", k), 32'(core_stall_req), 32'd0);
            idleCycles(2);
        end

        $display("[TB] all eight counters requested at once");
        for (int i = 0; i < NUM_CNT; i++) begin
            initVals[i] = i * 3 + 1;
            loadWord(BASE + i, initVals[i]);
        end
        applyStimulus('1, '0);
        collectWrites(8, 80, got);
        checkOutput("burstWriteCount", 32'(got), 32'd8);
        for (int i = 0; i < got; i++) begin
            v = refStep(initVals[i], 1'b0, ovfTmp);
            checkOutput($sformatf("burst%0d addr", i), 32'(wrAddr[i]), 32'(BASE + i));
            checkOutput($sformatf("burst%0d data", i), 32'(wrData[i]), 32'(v));
            checkOutput($sformatf("burst%0d stallGap", i), 32'(wrGap[i]), 32'(i == 0 || i == 4));
        end
        idleCycles(3);

        $display("[TB] inc and dec on one counter in the same cycle");
        loadWord(BASE + 3, 'o10);
        applyStimulus(8'h08, 8'h08);
        collectWrites(2, 30, got);
        checkOutput("incDecCount", 32'(got), 32'd2);
        checkOutput("incDecFirstAddr", 32'(wrAddr[0]), 32'(BASE + 3));
        checkOutput("incDecFirstData", 32'(wrData[0]), 32'o11);
        checkOutput("incDecSecondAddr", 32'(wrAddr[1]), 32'(BASE + 3));
        checkOutput("incDecSecondData", 32'(wrData[1]), 32'o10);
        idleCycles(3);

        $display("[TB] waiting for grant without timeout");
        loadWord(BASE + 6, 'o1234);
        core_grant = 1'b0;
        applyStimulus(8'h40, '0);
        sawWrite = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            sawWrite |= ram_write_en | ram_own;
        end
        checkOutput("noGrantStall", 32'(core_stall_req), 32'd1);
        checkOutput("noGrantNoRam", 32'(sawWrite), 32'd0);
        core_grant = 1'b1;
        waitWrite(10, cyc, seen);
        checkOutput("lateGrantWrite", 32'(seen), 32'd1);
        checkOutput("lateGrantData", 32'(ram_write_data), 32'o1235);
        idleCycles(3);

        $display("[TB] reset during MODIFY");
        loadWord(BASE + 5, 'o144);
        loadWord(BASE + 6, 'o555);
        applyStimulus(8'h20, 8'h40);
        for (int c = 0; c < 10 && !ram_own; c++) @(negedge clock);
        checkOutput("reachRead", 32'(ram_own), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("midRstStall", 32'(core_stall_req), 32'd0);
        checkOutput("midRstOwn", 32'(ram_own), 32'd0);
        checkOutput("midRstWrEn", 32'(ram_write_en), 32'd0);
        checkOutput("midRstOvf", 32'(overflow), 32'd0);
        checkOutput("midRstRdAddr", 32'(ram_read_address), 32'd0);
        checkOutput("midRstWrAddr", 32'(ram_write_address), 32'd0);
        checkOutput("midRstWrData", 32'(ram_write_data), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        sawWrite = 1'b0;
        sawStall = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            sawWrite |= ram_write_en;
            sawStall |= core_stall_req;
        end
        checkOutput("postRstNoWrite", 32'(sawWrite), 32'd0);
        checkOutput("postRstPendCleared", 32'(sawStall), 32'd0);
        checkOutput("postRstMem5", 32'(mem[BASE + 5]), 32'o144);
        checkOutput("postRstMem6", 32'(mem[BASE + 6]), 32'o555);

        $display("[TB] randomized run against reference model");
        specials = '{0, 'o37777, 'o40000, 'o77777, 'o77776, 1};
        for (int i = 0; i < NUM_CNT; i++) begin
            v = ($urandom % 2) ? specials[$urandom % 6] : int'($urandom % 32768);
            mCnt[i] = v;
            loadWord(BASE + i, v);
        end
        mPendInc   = '0;
        mPendDec   = '0;
        lastInc    = '0;
        lastDec    = '0;
        sinceRead  = -1;
        burstReads = 0;
        expIdx     = 0;
        expDec     = 1'b0;
        checkCont  = 1'b0;
        expectCont = 1'b0;
        for (int c = 0; c < 2400; c++) begin
            @(negedge clock);
            monitorStep();
            if (c < 2000) begin
                inc_req    = ($urandom % 3 == 0) ? NUM_CNT'($urandom & $urandom) : '0;
                dec_req    = ($urandom % 3 == 0) ? NUM_CNT'($urandom & $urandom) : '0;
                core_grant = ($urandom % 10) < 7;
            end else begin
                inc_req    = '0;
                dec_req    = '0;
                core_grant = 1'b1;
            end
            lastInc = inc_req;
            lastDec = dec_req;
        end
        checkOutput("drainStall", 32'(core_stall_req), 32'd0);
        checkOutput("drainPending", 32'({mPendInc, mPendDec}), 32'd0);
        for (int i = 0; i < NUM_CNT; i++) begin
            checkOutput($sformatf("finalCnt[%0d]", i), 32'(mem[BASE + i]), 32'(mCnt[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/counter_increment_arbiter.md
COUNTER_INCREMENT_ARBITER -- requirements
Module: counter_increment_arbiter

Interface
REQ-001 Parameter: NUM_CNT, default 8, number of involuntary counters serviced.
REQ-002 Parameter: CNT_BASE_ADDR, default 11'o24, erasable address of counter 0; counter i lives at CNT_BASE_ADDR+i.
REQ-003 Parameter: MAX_BURST, default 4, maximum counter updates per core stall.
REQ-004 Ports, in this order:
- clock  in  1  sole clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- inc_req  in  NUM_CNT  one-cycle pulse per counter; requests +1.
- dec_req  in  NUM_CNT  one-cycle pulse per counter; requests -1.
- core_stall_req  out  1  requests that the core pipeline freeze.
- core_grant  in  1  core is frozen and the RAM ports are free.
- ram_own  out  1  selects this block's RAM signals over the core's at the external RAM mux.
- ram_read_address  out  11  erasable read address.
- ram_read_data  in  15  synchronous RAM read data, valid one cycle after the address.
- ram_write_address  out  11  erasable write address.
- ram_write_data  out  15  updated counter word.
- ram_write_en  out  1  single-cycle write strobe.
- overflow  out  NUM_CNT  one-cycle pulse per counter on one's-complement overflow.

Function
REQ-005 Each counter has a pending_inc bit and a pending_dec bit; a request pulse sets the matching bit.
REQ-006 A pulse arriving while its bit is already set is absorbed; no queue depth beyond one per direction.
REQ-007 Selection is fixed priority: lowest index with any pending bit; within one counter, inc is selected before dec.
REQ-008 The selected pending bit clears on entry to READ; a set and a clear of the same bit in the same cycle leave it set.
REQ-009 FSM states: IDLE, WAIT_GRANT, READ, MODIFY, WRITE.
- IDLE: any pending bit set -> WAIT_GRANT.
- WAIT_GRANT: core_grant=1 -> READ.
- READ -> MODIFY -> WRITE, one cycle each.
- WRITE: if another bit is pending and fewer than MAX_BURST updates are done in this stall -> READ; otherwise -> IDLE.
REQ-010 core_stall_req is 1 in WAIT_GRANT, READ, MODIFY and WRITE; otherwise 0.
REQ-011 ram_own is 1 in READ, MODIFY and WRITE; otherwise 0.
REQ-012 After a return from WRITE to IDLE, core_stall_req stays 0 for at least one cycle before WAIT_GRANT is re-entered (core fairness).
REQ-013 READ drives ram_read_address=CNT_BASE_ADDR+sel; MODIFY captures ram_read_data and computes the result.
REQ-014 WRITE drives ram_write_en=1, ram_write_address=CNT_BASE_ADDR+sel and ram_write_data=result; ram_write_en is 0 in every other state.
REQ-015 Increment rule (15-bit one's complement):
- o37777 -> o00000, with overflow.
- o77777 (-0) -> o00001.
- otherwise value+1 modulo 2^15.
REQ-016 Decrement rule:
- o40000 -> o77777, with overflow.
- o00000 (+0) -> o77776.
- otherwise value-1 modulo 2^15.
REQ-017 overflow[sel] pulses high for exactly the WRITE cycle of an overflowing update.
REQ-018 core_grant dropping after READ is entered is ignored; the update completes.
REQ-019 Minimum latency from a request pulse to ram_write_en is 5 cycles when core_grant is already 1; there is no timeout in WAIT_GRANT.

Reset
REQ-020 reset=1 forces, asynchronously: state=IDLE, all pending bits 0, burst count 0, and all outputs 0 (core_stall_req, ram_own, ram_write_en, overflow, both addresses, ram_write_data).
REQ-021 A reset in mid-update aborts it with no write strobe, and all pending requests are discarded.

Structure
REQ-022 The shared package holds the FSM state enum typedef and the constants POS_MAX=o37777, NEG_MAX=o40000, NEG_ZERO=o77777 and CNT_BASE_ADDR default.
REQ-023 The +/-1 rule is a combinational sub-module ones_comp_step (inputs: value, dir; outputs: result, ovf), instantiated once.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- inc_req[2] pulse, grant held 1, RAM[o26]=o00005 -> write o00006 to o26, 5 cycles after the pulse; overflow=0.
- inc_req[0] pulse, RAM[o24]=o37777 -> write o00000; overflow[0] pulses in the WRITE cycle.
- dec_req[1] pulse, RAM[o25]=o00000 -> write o77776; a second case with RAM[o25]=o40000 -> write o77777 with overflow[1].
- inc_req[7:0]=8'hFF in one cycle -> counters 0..3 updated in the first stall; stall_req=0 for at least one cycle; then counters 4..7 updated in the second stall.
- inc_req[3] and dec_req[3] in the same cycle, RAM[o27]=o00010 -> inc written first (o00011), then dec (o00010).
- reset asserted during MODIFY -> no ram_write_en; all outputs 0 immediately; pending bits cleared.
